// File: rtl/baud_gen_frac_pkg.sv
// baud_pkg: shared constants for the fractional baud tick generator.
//   - default widths, oversample ratio and post-reset divisor
//   - standard divisor presets for a 50 MHz system clock
//   - clog2 helper used to size the oversample phase counter
package baud_pkg;

  localparam int unsigned BAUD_DIV_W    = 16;
  localparam int unsigned BAUD_FRAC_W   = 4;
  localparam int unsigned BAUD_OVS      = 16;
  localparam int unsigned BAUD_DEF_DIV  = 326;  // 9600 baud x16 at 50 MHz, integer only
  localparam int unsigned BAUD_DEF_FRAC = 0;

  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } baud_preset_t;

  // 50e6 / (baud * 16) = div_int + div_frac/16
  localparam baud_preset_t BAUD_9600_50M   = '{div_int: 16'd325, div_frac: 4'd8};
  localparam baud_preset_t BAUD_115200_50M = '{div_int: 16'd27,  div_frac: 4'd2};

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: control and tick bundle of one baud generator channel.
//   master: drives enable, sync_clr, div_load, div_int, div_frac
//   slave : drives os_tick, mid_tick, bit_tick, os_phase, cfg_err
interface baud_gen_frac_if
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W  = BAUD_DIV_W,
  parameter int unsigned FRAC_W = BAUD_FRAC_W,
  parameter int unsigned OVS    = BAUD_OVS
);
  localparam int unsigned PH_W = clog2(OVS);

  logic              enable;
  logic              sync_clr;
  logic              div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   os_phase;
  logic              cfg_err;

  modport master (
    output enable, sync_clr, div_load, div_int, div_frac,
    input  os_tick, mid_tick, bit_tick, os_phase, cfg_err
  );

  modport slave (
    input  enable, sync_clr, div_load, div_int, div_frac,
    output os_tick, mid_tick, bit_tick, os_phase, cfg_err
  );

endinterface

// File: rtl/baud_gen_frac_accum.sv
// frac_accum: fractional phase accumulator of the baud generator.
//   clk, reset_n : clock, async active-low reset
//   clr_i        : clear accumulator (priority over advance)
//   adv_i        : add frac_i at a period boundary
//   frac_i       : active fractional divisor
//   carry_o      : carry-out of acc + frac_i; lengthens the current period by one
module frac_accum #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, frac_i};
    carry_o = sum[FRAC_W];
    acc_d   = acc_q;
    if (clr_i)      acc_d = '0;
    else if (adv_i) acc_d = sum[FRAC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-divisor oversample / mid-bit / bit tick generator.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of baud_gen_frac_if
//              in : enable, sync_clr, div_load, div_int, div_frac
//              out: os_tick, mid_tick, bit_tick (registered one-cycle pulses),
//                   os_phase (os_ticks since bit boundary), cfg_err (sticky)
// Period length is div_int + carry, where carry comes from the fractional
// accumulator, giving an average period of div_int + div_frac/2^FRAC_W.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W    = BAUD_DIV_W,
  parameter int unsigned FRAC_W   = BAUD_FRAC_W,
  parameter int unsigned OVS      = BAUD_OVS,
  parameter int unsigned DEF_DIV  = BAUD_DEF_DIV,
  parameter int unsigned DEF_FRAC = BAUD_DEF_FRAC
) (
  input logic            clk,
  input logic            reset_n,
  baud_gen_frac_if.slave bus
);
  localparam int unsigned PH_W  = clog2(OVS);
  localparam int unsigned CNT_W = DIV_W + 1;

  logic [DIV_W-1:0]  div_int_q, div_int_d, shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d, shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              os_q, os_d, mid_q, mid_d, bit_q, bit_d;
  logic              err_q, err_d;

  logic              carry;
  logic              ld_bad;
  logic [DIV_W-1:0]  ld_int;
  logic [CNT_W-1:0]  end_val;
  logic              period_end;
  logic              load_now;
  logic              acc_clr;

  frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (acc_clr),
    .adv_i   (period_end),
    .frac_i  (div_frac_q),
    .carry_o (carry)
  );

  always_comb begin
    ld_bad     = bus.div_int < DIV_W'(2);
    ld_int     = ld_bad ? DIV_W'(2) : bus.div_int;
    end_val    = {1'b0, div_int_q} + CNT_W'(carry) - CNT_W'(1);
    // sync_clr wins over a coincident period end, suppressing that tick
    period_end = bus.enable && !bus.sync_clr && (cnt_q >= end_val);
    // A load takes effect at once when disabled or clearing; a load landing
    // on a boundary is applied there directly instead of waiting a period.
    load_now   = bus.div_load && (!bus.enable || bus.sync_clr || period_end);
    acc_clr    = bus.sync_clr || (bus.div_load && !bus.enable);
  end

  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    err_d      = err_q || (bus.div_load && ld_bad);

    if (bus.div_load) begin
      shd_int_d  = ld_int;
      shd_frac_d = bus.div_frac;
    end

    if (load_now) begin
      div_int_d  = ld_int;
      div_frac_d = bus.div_frac;
      pend_d     = 1'b0;
    end else if (bus.div_load) begin
      pend_d = 1'b1;
    end else if (period_end && pend_q) begin
      div_int_d  = shd_int_q;
      div_frac_d = shd_frac_q;
      pend_d     = 1'b0;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    os_d    = 1'b0;
    mid_d   = 1'b0;
    bit_d   = 1'b0;

    if (bus.sync_clr) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (bus.div_load && !bus.enable) begin
      cnt_d = '0;
    end else if (bus.enable) begin
      if (period_end) begin
        cnt_d   = '0;
        os_d    = 1'b1;
        mid_d   = (phase_q == PH_W'(OVS/2 - 1));
        bit_d   = (phase_q == PH_W'(OVS - 1));
        phase_d = phase_q + PH_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_int_q  <= DIV_W'(DEF_DIV);
      div_frac_q <= FRAC_W'(DEF_FRAC);
      shd_int_q  <= DIV_W'(DEF_DIV);
      shd_frac_q <= FRAC_W'(DEF_FRAC);
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= '0;
      os_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      os_q       <= os_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
    end
  end

  assign bus.os_tick  = os_q;
  assign bus.mid_tick = mid_q;
  assign bus.bit_tick = bit_q;
  assign bus.os_phase = phase_q;
  assign bus.cfg_err  = err_q;

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the fixed-divide x16 baud tick generator.
- Generates a programmable oversample tick, a mid-bit tick and a bit tick from one system clock.
- Supports a fractional divisor, runtime divisor reload without runt periods, phase re-sync for RX start-bit alignment, and an enable.
- Shared by UART TX (uses bit_tick) and RX (uses os_tick/mid_tick); one instance per channel.

Parameters:
- DIV_W, 16, width of the integer divisor (cycles per oversample period).
- FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W cycle).
- OVS, 16, oversample ticks per bit; power of two, 4..32.
- DEF_DIV, 326, integer divisor after reset (9600 baud x16 at 50 MHz).
- DEF_FRAC, 0, fractional divisor after reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  count enable; low freezes all state.
- sync_clr  in  1  single-cycle pulse; restarts period and phase.
- div_load  in  1  single-cycle pulse; captures div_int/div_frac.
- div_int  in  DIV_W  new integer divisor.
- div_frac  in  FRAC_W  new fractional divisor.
- os_tick  out  1  one-cycle oversample pulse.
- mid_tick  out  1  one-cycle pulse on the os_tick where phase = OVS/2-1.
- bit_tick  out  1  one-cycle pulse on the os_tick where phase = OVS-1.
- os_phase  out  log2(OVS)  os_ticks since last bit boundary, mod OVS.
- cfg_err  out  1  sticky flag: a div_int < 2 was loaded.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): cnt=0, acc=0, os_phase=0, all tick outputs=0, cfg_err=0, active divisor=DEF_DIV/DEF_FRAC, shadow divisor=same, no pending load.
- Period: P = div_int_active + carry. carry is the carry-out of acc + div_frac_active, evaluated at the start of each period. acc updates at each os_tick.
  - Average period = div_int + div_frac/2^FRAC_W.
  - cnt is DIV_W+1 bits wide.
- Ticks: cnt increments each enabled cycle. When cnt = P-1, cnt goes to 0 and the registered os_tick is high the next cycle.
  - With enable high from reset release and frac=0, os_tick is high after edges P, 2P, 3P, and so on.
- os_phase increments mod OVS on every os_tick.
  - mid_tick and bit_tick are registered with os_tick and evaluated on the phase value before the increment.
- enable low: cnt, acc, os_phase and the pending load all hold; tick outputs are 0. Resuming continues the interrupted period.
- div_load with enable high: the shadow divisor is captured and applied at the next period boundary, in the same cycle os_tick is generated. The current period completes at the old length.
- div_load with enable low: applies immediately; cnt and acc are cleared.
- div_int < 2 is loaded as 2 and sets cfg_err. cfg_err clears only on reset.
- sync_clr: cnt=0, acc=0, os_phase=0; no tick in the following cycle. The next os_tick comes P cycles later with phase 0→1.
- sync_clr together with div_load: the new divisor is applied immediately, then the clear takes effect.
- sync_clr takes priority over a coincident period end; that tick is suppressed.
- reset_n asserted mid-period clears all outputs asynchronously within the same cycle.

Decomposition:
- baud_pkg:
  - OVS and DIV_W defaults.
  - DEF_DIV / DEF_FRAC constants.
  - A clog2 function.
  - Standard divisor presets (9600, 115200 @ 50 MHz).
- No sub-module is required. The fractional accumulator may optionally be split out as frac_accum: acc register, add and carry-out, with clear and advance inputs.

Test Plan:
- Reset defaults, enable=1:
  - os_tick every 326 cycles; first os_tick after edge 326.
  - mid_tick on the 8th os_tick (cycle 2608).
  - bit_tick every 5216 cycles; os_phase steps 0..15.
- Fractional divisor: load div_int=27, div_frac=2 while disabled, then enable.
  - 8 consecutive periods total exactly 217 cycles: seven of 27 and one of 28.
  - 16 periods total exactly 434 cycles.
- Reload mid-period: div_load of 10 at cnt=100 under DEF_DIV.
  - Current period still ends at 326.
  - Following periods are exactly 10 cycles.
- sync_clr at os_phase=9:
  - No tick next cycle.
  - Next os_tick after 326 cycles, os_phase=1.
  - mid_tick on the 8th and bit_tick on the 16th os_tick after the clear.
- enable dropped for 50 cycles at cnt=200:
  - Next os_tick is 50 cycles late.
  - reset_n low mid-period forces all outputs to 0 before the next clk edge.
- div_int=1 loaded: cfg_err=1, period=2 cycles; cfg_err stays 1 after a later valid load until reset.
